// File: rtl/mist_frame_trig.sv
// rtl/mist_frame_trig.sv - frame counter and dump-window generator for the MiST harness
module mist_frame_trig #(
  parameter int unsigned START_FRAME = 0,
  parameter int unsigned STOP_FRAME  = 0,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned DL_GUARD    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vga_vs,
  input  logic             downloading,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             frame_tick,
  output logic             dump_en,
  output logic             dump_start,
  output logic             dump_stop,
  output logic [1:0]       st
);

  localparam logic [1:0] S_WAIT_DL = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_DUMPING = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [CNT_W-1:0] START_V = CNT_W'(START_FRAME);
  localparam logic [CNT_W-1:0] STOP_V  = CNT_W'(STOP_FRAME);
  localparam logic [7:0]       GUARD_V = 8'(DL_GUARD);

  logic             r_vs_meta;
  logic             r_vs_sync;
  logic             r_vs_prev;
  logic             r_tick;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_guard;
  logic [1:0]       r_st;
  logic [1:0]       r_prev_st;
  logic [1:0]       w_st_nxt;
  logic             w_fall;
  logic             w_start_hit;
  logic             w_stop_hit;

  // two synchroniser flops plus one history flop for edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vs_meta <= 1'b0;
      r_vs_sync <= 1'b0;
      r_vs_prev <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_vs_meta <= vga_vs;
      r_vs_sync <= r_vs_meta;
      r_vs_prev <= r_vs_sync;
      r_tick    <= w_fall;
    end
  end

  assign w_fall = r_vs_prev & ~r_vs_sync;

  // count moves with the tick so both are visible in the same cycle
  always_ff @(posedge clk) begin
    if (!rst_n || (r_st == S_WAIT_DL) || downloading) begin
      r_cnt <= '0;
    end else if (w_fall) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || downloading) begin
      r_guard <= GUARD_V;
    end else if ((r_st == S_WAIT_DL) && (r_guard != 8'd0)) begin
      r_guard <= r_guard - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_st      <= S_WAIT_DL;
      r_prev_st <= S_WAIT_DL;
    end else begin
      r_st      <= w_st_nxt;
      r_prev_st <= r_st;
    end
  end

  // matches use the registered tick/count pair, so they act one edge later
  assign w_start_hit = (START_FRAME == 0) || (r_tick && (r_cnt == START_V));
  assign w_stop_hit  = (STOP_FRAME != 0) && r_tick && (r_cnt == STOP_V);

  always_comb begin
    w_st_nxt = r_st;
    case (r_st)
      S_WAIT_DL: if (!downloading && (r_guard <= 8'd1)) w_st_nxt = S_ARMED;
      S_ARMED: begin
        if (downloading)      w_st_nxt = S_WAIT_DL;
        else if (w_start_hit) w_st_nxt = S_DUMPING;
      end
      S_DUMPING: begin
        if (downloading)     w_st_nxt = S_WAIT_DL;
        else if (w_stop_hit) w_st_nxt = S_DONE;
      end
      S_DONE: if (downloading) w_st_nxt = S_WAIT_DL;
      default: w_st_nxt = S_WAIT_DL;
    endcase
  end

  // a reset clears r_prev_st too, so leaving DUMPING by reset gives no stop pulse
  always_comb begin
    dump_en    = 1'b0;
    dump_start = 1'b0;
    dump_stop  = 1'b0;
    if (r_st == S_DUMPING) begin
      dump_en    = 1'b1;
      dump_start = (r_prev_st == S_ARMED);
    end else begin
      dump_stop  = (r_prev_st == S_DUMPING);
    end
  end

  assign frame_cnt  = r_cnt;
  assign frame_tick = r_tick;
  assign st         = r_st;

endmodule

// File: tb/tb_mist_frame_trig.sv
// tb/tb_mist_frame_trig.sv - randomized bench for mist_frame_trig against a behavioural model
module tb_mist_frame_trig;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vga_vs = 1'b0;
  logic        downloading = 1'b0;
  logic [31:0] cnt_a;
  logic [3:0]  cnt_b;
  logic [7:0]  cnt_c;
  logic [2:0]  tick, en, start, stop;
  logic [1:0]  st_a, st_b, st_c;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mist_frame_trig #(.START_FRAME(3), .STOP_FRAME(6), .CNT_W(32), .DL_GUARD(16)) u_a (
    .clk(clk), .rst_n(rst_n), .vga_vs(vga_vs), .downloading(downloading),
    .frame_cnt(cnt_a), .frame_tick(tick[0]), .dump_en(en[0]), .dump_start(start[0]),
    .dump_stop(stop[0]), .st(st_a));
  mist_frame_trig #(.START_FRAME(0), .STOP_FRAME(0), .CNT_W(4), .DL_GUARD(5)) u_b (
    .clk(clk), .rst_n(rst_n), .vga_vs(vga_vs), .downloading(downloading),
    .frame_cnt(cnt_b), .frame_tick(tick[1]), .dump_en(en[1]), .dump_start(start[1]),
    .dump_stop(stop[1]), .st(st_b));
  mist_frame_trig #(.START_FRAME(2), .STOP_FRAME(3), .CNT_W(8), .DL_GUARD(1)) u_c (
    .clk(clk), .rst_n(rst_n), .vga_vs(vga_vs), .downloading(downloading),
    .frame_cnt(cnt_c), .frame_tick(tick[2]), .dump_en(en[2]), .dump_start(start[2]),
    .dump_stop(stop[2]), .st(st_c));

  // model parameters per instance
  int unsigned p_start [3] = '{3, 0, 2};
  int unsigned p_stop  [3] = '{6, 0, 3};
  int unsigned p_w     [3] = '{32, 4, 8};
  int          p_g     [3] = '{16, 5, 1};

  // model state: mode 0 WAIT_DL, 1 ARMED, 2 DUMPING, 3 DONE
  int              m_mode [3];
  int              m_prev [3];
  int              m_guard[3];
  longint unsigned m_cnt  [3];
  bit              m_tick [3];
  bit              h1 = 0, h2 = 0, h3 = 0;

  int vs_ph = 0, vs_per = 100, vs_hi = 4;
  bit vs_auto = 0, vs_rand = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] obs(input int i);
    logic [31:0] c;
    c = (i == 0) ? cnt_a : (i == 1) ? {28'd0, cnt_b} : {24'd0, cnt_c};
    return {26'd0, (i == 0) ? st_a : (i == 1) ? st_b : st_c, stop[i], start[i], en[i], tick[i], c};
  endfunction

  function automatic logic [63:0] expv(input int i);
    logic [1:0] m;
    logic e, s, p;
    m = 2'(m_mode[i]);
    e = (m_mode[i] == 2);
    s = (m_mode[i] == 2) && (m_prev[i] == 1);
    p = (m_prev[i] == 2) && (m_mode[i] != 2);
    return {26'd0, m, p, s, e, m_tick[i], m_cnt[i][31:0]};
  endfunction

  // a tick follows a synchronised 1-then-0 pair, three edges after the pin sample
  task automatic model_step();
    bit t;
    longint unsigned mask;
    bit otick;
    longint unsigned ocnt;
    int old;
    t  = rst_n && h3 && !h2;
    h3 = h2; h2 = h1; h1 = rst_n ? vga_vs : 1'b0;
    for (int i = 0; i < 3; i++) begin
      mask = (64'd1 << p_w[i]) - 64'd1;
      if (!rst_n) begin
        m_mode[i] = 0; m_prev[i] = 0; m_guard[i] = p_g[i]; m_cnt[i] = 0; m_tick[i] = 0;
      end else begin
        otick = m_tick[i]; ocnt = m_cnt[i]; old = m_mode[i];
        m_prev[i] = old;
        m_tick[i] = t;
        if (old == 0) begin
          m_cnt[i] = 0;
          if (downloading) m_guard[i] = p_g[i];
          else begin
            m_guard[i]--;
            if (m_guard[i] <= 0) m_mode[i] = 1;
          end
        end else if (downloading) begin
          m_mode[i] = 0; m_cnt[i] = 0; m_guard[i] = p_g[i];
        end else begin
          if (old == 1 && (p_start[i] == 0 || (otick && ocnt == p_start[i]))) m_mode[i] = 2;
          if (old == 2 && p_stop[i] != 0 && otick && ocnt == p_stop[i]) m_mode[i] = 3;
          if (t) m_cnt[i] = (m_cnt[i] + 1) & mask;
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    model_step();
    for (int i = 0; i < 3; i++) chk_eq($sformatf("model_%0d", i), obs(i), expv(i));
    if (vs_auto) begin
      vs_ph++;
      if (vs_ph >= vs_per) begin
        vs_ph = 0;
        if (vs_rand) vs_per = $urandom_range(30, 8);
      end
      vga_vs = (vs_ph < vs_hi);
    end
  endtask

  initial begin
    int k, s_cnt, p_cnt, en_cyc, nt, en_low, nstop, dl_left, rst_left;

    // boot: START=3, STOP=6
    repeat (4) cycle();
    chk_eq("reset_a", obs(0), 64'd0);
    rst_n = 1'b1; vs_auto = 1;
    repeat (15) cycle();
    chk_eq("arm_15clk", st_a, 2'd0);
    cycle();
    chk_eq("arm_16clk", st_a, 2'd1);
    s_cnt = -1; p_cnt = -1; en_cyc = 0; k = 0;
    while (st_a != 2'd3 && k < 1200) begin
      cycle(); k++;
      if (start[0]) s_cnt = int'(cnt_a);
      if (stop[0])  p_cnt = int'(cnt_a);
      if (en[0])    en_cyc++;
    end
    chk_eq("boot_done", st_a, 2'd3);
    chk_eq("boot_start_cnt", 64'(s_cnt), 64'd3);
    chk_eq("boot_stop_cnt", 64'(p_cnt), 64'd6);
    chk_eq("boot_en_cycles", 64'(en_cyc), 64'd300);

    // START=0/STOP=0 instance keeps dumping across 1000 frames and wraps
    vs_rand = 1; nt = 0; en_low = 0; nstop = 0; k = 0;
    while (nt < 1000 && k < 40000) begin
      cycle(); k++;
      if (tick[1]) nt++;
      if (!en[1]) en_low++;
      if (stop[1]) nstop++;
    end
    chk_eq("b_frames", 64'(nt), 64'd1000);
    chk_eq("b_en_low", 64'(en_low), 64'd0);
    chk_eq("b_stops", 64'(nstop), 64'd0);

    // download mid-dump
    vs_rand = 0; vs_per = 100;
    downloading = 1'b1; repeat (3) cycle(); downloading = 1'b0;
    k = 0;
    while (!(st_a == 2'd2 && cnt_a == 32'd4 && tick[0]) && k < 2000) begin cycle(); k++; end
    chk_eq("dl_reach_f4", 64'(k < 2000), 64'd1);
    downloading = 1'b1;
    cycle();
    chk_eq("dl_stop", stop[0], 1'b1);
    chk_eq("dl_cnt", cnt_a, 32'd0);
    chk_eq("dl_st", st_a, 2'd0);
    downloading = 1'b0; k = 0;
    while (st_a != 2'd1 && k < 100) begin cycle(); k++; end
    chk_eq("rearm_clk", 64'(k), 64'd16);
    k = 0;
    while (!start[0] && k < 1000) begin cycle(); k++; end
    chk_eq("restart_seen", start[0], 1'b1);
    chk_eq("restart_cnt", cnt_a, 32'd3);

    // download rising with the edge that raises frame_tick
    vs_auto = 0; vga_vs = 1'b1;
    repeat (6) cycle();
    vga_vs = 1'b0;
    cycle(); cycle();
    downloading = 1'b1;
    cycle();
    chk_eq("coll_tick", tick[0], 1'b1);
    chk_eq("coll_cnt", cnt_a, 32'd0);
    chk_eq("coll_st", st_a, 2'd0);
    downloading = 1'b0;

    // one-clock vga_vs pulse
    repeat (4) cycle();
    vga_vs = 1'b1; cycle(); vga_vs = 1'b0;
    nt = 0;
    repeat (8) begin cycle(); if (tick[0]) nt++; end
    chk_eq("glitch_ticks", 64'(nt <= 1), 64'd1);

    // random downloads, resets and sync periods
    vs_auto = 1; vs_rand = 1; dl_left = 0; rst_left = 0;
    for (int c = 0; c < 8000; c++) begin
      if (dl_left > 0) dl_left--;
      else if ($urandom_range(299, 0) == 0) dl_left = $urandom_range(20, 1);
      if (rst_left > 0) rst_left--;
      else if ($urandom_range(1999, 0) == 0) rst_left = $urandom_range(3, 1);
      downloading = (dl_left > 0);
      rst_n = (rst_left == 0);
      cycle();
    end

    // reset while dumping
    downloading = 1'b0; rst_n = 1'b1; k = 0;
    while (st_b != 2'd2 && k < 200) begin cycle(); k++; end
    chk_eq("b_dumping", st_b, 2'd2);
    rst_n = 1'b0;
    cycle();
    chk_eq("rst_b_outs", obs(1), 64'd0);
    chk_eq("rst_no_stop", stop, 3'd0);
    rst_n = 1'b1;
    repeat (5) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
